// File: rtl/ps2_kbmat.sv
// PS/2 keyboard receiver and scancode decoder for the Z88 gate array.
// Keeps the 64-bit key matrix image (bit row*8+col = 1 while held).
module ps2_kbmat #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 2000
) (
    input  logic        mck,
    input  logic        rin,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [63:0] kbmat,
    output logic        scan_vld,
    output logic [7:0]  scan_code,
    output logic        frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   clk_last;
    logic                   fall_q;
    logic                   dat_q;

    state_t      state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [63:0] kbmat_d;
    logic [7:0]  scan_code_d;
    logic        good_c, err_c;
    logic [6:0]  lookup_c;

    // {hit, matrix bit} for {ext, scancode}
    function automatic logic [6:0] key_lookup(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h05A: return {1'b1, 6'd6};   // ENTER
            9'h066: return {1'b1, 6'd7};   // BACKSPACE -> DEL
            9'h01A: return {1'b1, 6'd42};  // Z
            9'h01C: return {1'b1, 6'd44};  // A
            9'h016: return {1'b1, 6'd45};  // 1
            9'h029: return {1'b1, 6'd46};  // SPACE
            9'h00D: return {1'b1, 6'd53};  // TAB
            9'h012: return {1'b1, 6'd54};  // LSHIFT
            9'h174: return {1'b1, 6'd56};  // RIGHT
            9'h16B: return {1'b1, 6'd57};  // LEFT
            9'h172: return {1'b1, 6'd58};  // DOWN
            9'h175: return {1'b1, 6'd59};  // UP
            9'h076: return {1'b1, 6'd61};  // ESC
            9'h059: return {1'b1, 6'd63};  // RSHIFT
            default: return 7'd0;
        endcase
    endfunction

    // Synchronisers and falling-edge detect; fill_q blocks a false edge from
    // the reset value of the chain when the line is already low.
    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            clk_sync <= '1;
            dat_sync <= '1;
            fill_q   <= '0;
            clk_last <= 1'b1;
            fall_q   <= 1'b0;
            dat_q    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
            fill_q   <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            clk_last <= clk_sync[SYNC_STAGES-1];
            fall_q   <= fill_q[SYNC_STAGES] & clk_last & ~clk_sync[SYNC_STAGES-1];
            dat_q    <= dat_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge mck or posedge rin) begin
        if (rin) begin
            state_q   <= IDLE;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            kbmat     <= 64'd0;
            scan_code <= 8'd0;
            scan_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            kbmat     <= kbmat_d;
            scan_code <= scan_code_d;
            scan_vld  <= good_c;
            frame_err <= err_c;
        end
    end

    assign lookup_c = key_lookup(ext_q, shift_q);

    // Receive FSM, timeout and scancode decode
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_ok_d    = par_ok_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        kbmat_d     = kbmat;
        scan_code_d = scan_code;
        good_c      = 1'b0;
        err_c       = 1'b0;

        // Counter includes the edge cycle so the abort lands TIMEOUT cycles after it
        if (fall_q)
            tmo_d = TW'(1);
        else if (state_q == IDLE)
            tmo_d = '0;
        else if (tmo_q == TW'(TIMEOUT))
            tmo_d = tmo_q;
        else
            tmo_d = tmo_q + TW'(1);

        case (state_q)
            IDLE: if (fall_q) begin
                if (!dat_q) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                end else begin
                    err_c = 1'b1;
                end
            end
            DATA: if (fall_q) begin
                shift_d = {dat_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7)
                    state_d = PARITY;
            end
            PARITY: if (fall_q) begin
                par_ok_d = ^{shift_q, dat_q};
                state_d  = STOP;
            end
            STOP: if (fall_q) begin
                if (dat_q && par_ok_q)
                    good_c = 1'b1;
                else
                    err_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && !fall_q && tmo_d == TW'(TIMEOUT)) begin
            err_c   = 1'b1;
            state_d = IDLE;
        end

        if (err_c) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end

        if (good_c) begin
            scan_code_d = shift_q;
            case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'hAA: begin
                    kbmat_d = 64'd0;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                end
                8'hE1, 8'h00, 8'hFF: ;
                default: begin
                    if (lookup_c[6])
                        kbmat_d[lookup_c[5:0]] = ~brk_q;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_kbmat.md
# ps2_kbmat

Keyboard front end for the Z88 gate array. It receives PS/2 device-to-host frames from an external keyboard and decodes make and break scancodes, including the E0 and F0 prefixes. It maintains the 64-bit key matrix image consumed directly on the gate array's `kbmat` input, where bit `row*8+col` is 1 while that key is held. All logic runs on the master clock; the PS/2 lines are asynchronous inputs.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the `ps2_clk`/`ps2_dat` synchronisers (minimum 2).
- `TIMEOUT`, default 2000: number of `mck` cycles without a falling `ps2_clk` edge before an in-progress frame is aborted (about 200 µs at 9.83 MHz).
- `mck` in 1: 9.83 MHz master clock; the only clock in the block.
- `rin` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: PS/2 clock line, asynchronous to `mck`.
- `ps2_dat` in 1: PS/2 data line, asynchronous to `mck`.
- `kbmat` out 64: key matrix image; 1 = pressed.
- `scan_vld` out 1: one-cycle pulse when a good frame completes.
- `scan_code` out 8: byte of the last good frame; held between pulses.
- `frame_err` out 1: one-cycle pulse when a frame is rejected or times out.

## Operation
- **Synchronisers:** both lines pass through `SYNC_STAGES` flops. A falling edge is the synchronised clock going 1→0 on consecutive cycles.
- **Receive FSM states:** IDLE, DATA, PARITY, STOP. All sampling of `ps2_dat` (synchronised) happens on a falling edge.
  - IDLE: a sample of 0 moves to DATA with the bit count cleared. A sample of 1 is an error.
  - DATA: shift the 8 data bits in LSB-first. After bit 7 move to PARITY.
  - PARITY: sample the parity bit. Odd parity over data plus parity is required. Always move to STOP.
  - STOP: a sample of 1 with good parity gives a good frame. Otherwise it is an error. Return to IDLE in either case.
- **Timeout:** the timeout counter clears on every falling edge and in IDLE. It saturates at `TIMEOUT`. Reaching `TIMEOUT` outside IDLE is an error and returns the FSM to IDLE.
- **Error handling:** pulse `frame_err`, discard the byte, and clear both prefix flags.
- **Good frame:** load `scan_code`, pulse `scan_vld`, then decode:
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - 0xAA (keyboard self-test pass) clears all of `kbmat` and both flags.
  - 0xE1 and 0x00/0xFF are ignored; they do not clear the flags.
  - Any other byte is looked up as {`ext`, byte}. If mapped, the target `kbmat` bit is set to `!brk`. Both flags then clear, whether or not the code was mapped.
- **Mandatory map** (remaining entries follow the Z88 keyboard matrix document, one entry per matrix position):
  - 0x5A ENTER → bit 6
  - 0x1C A → bit 44
  - 0x29 SPACE → bit 46
  - 0x12 LSHIFT → bit 54
  - 0x59 RSHIFT → bit 63
  - E0 0x75 UP → bit 59
  - 0x76 ESC → bit 61
- Unmapped codes leave `kbmat` unchanged. Multiple bits may be set at once; there is no ghosting logic.

## Timing
- **Reset values:**
  - FSM is in IDLE; flags, counters and shift register are 0.
  - Outputs: `kbmat`=0, `scan_code`=0x00, `scan_vld`=0, `frame_err`=0.
  - Synchroniser flops reset to 1 (idle bus). A line held low through reset does not produce a falling edge when reset is released.
  - Reset asserted mid-frame aborts the frame with no `frame_err` pulse.
- **Edge latency:** a falling edge is detected `SYNC_STAGES`+1 cycles after the `ps2_clk` pin transition. Data is sampled from the same-aligned synchronised `ps2_dat`.
- **Frame completion:** `scan_vld` and `frame_err` assert on the cycle after the stop-bit edge is detected. `kbmat` updates in that same cycle. The next bus cycle sees the new value.
- **Timeout:** `frame_err` asserts exactly `TIMEOUT` cycles after the last detected falling edge.
- **Exclusivity:** `scan_vld` and `frame_err` are never high together.
- **Edge with timeout:** an edge in the cycle the counter reaches `TIMEOUT` counts as an edge (no timeout).
- **Glitch tolerance:** the FSM consumes at most one bit per detected edge. Edges closer together than one `mck` cycle are not required to be resolved.

## Test plan
- **Make/break of A:** send 0x1C, then 0xF0 0x1C at 12 kHz. Required: `kbmat[44]`=1 after the first frame and 0 after the third; `scan_vld` pulses 3 times; `scan_code` ends at 0x1C.
- **Extended key and prefix scoping:** send E0 75, then 75. Required: only bit 59 sets; plain 0x75 (unmapped) leaves `kbmat` unchanged. Then E0 F0 75 clears bit 59.
- **Parity error:** send 0x29 with a bad parity bit. Required: one `frame_err` pulse, `kbmat[46]` stays 0, no `scan_vld`. A following good 0x29 sets bit 46.
- **Timeout:** send start plus 4 data bits, then hold the clock high. Required: `frame_err` exactly `TIMEOUT` cycles after the 5th edge, FSM back in IDLE. A subsequent 0x5A frame sets bit 6.
- **Multi-key and self-test clear:** press 0x12, 0x59, 0x76. Required: bits 54, 63 and 61 all set. Then 0xAA clears all of `kbmat` to 0.
- **Reset mid-frame:** assert `rin` after 3 data bits with bit 6 set. Required: immediate `kbmat`=0, no `frame_err`; a fresh complete frame decodes correctly.
